// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default bit timing and parity modes.
// Used by fifo_uart_tx and intended for the matching receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_START   = 3'd3,
    ST_DATA    = 3'd4,
    ST_PARITY  = 3'd5,
    ST_STOP    = 3'd6
  } uart_state_e;

  // 100 MHz system clock at 115200 baud.
  localparam int DEFAULT_CLKS_PER_BIT = 868;
  localparam int MIN_CLKS_PER_BIT     = 4;

  localparam int PARITY_MODE_EVEN = 0;
  localparam int PARITY_MODE_ODD  = 1;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last and
// second-to-last cycle of each bit. A synchronous load parks it at zero.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst_ni,
  input  logic load_i,
  output logic bit_end_o,
  output logic bit_pre_end_o
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (load_i || cnt_q == LAST) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_end_o     = (cnt_q == LAST);
  // Lets the FSM register a pulse that lands on the final cycle of a bit.
  assign bit_pre_end_o = (cnt_q == PRE);

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops one byte per frame from a synchronous FIFO and sends it
// as a UART frame (start, LSB-first data, optional parity, stop bits) on tx.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_W       = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IW-1:0] LAST_DATA = IW'(DATA_W - 1);
  localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

  uart_state_e       state_q;
  logic [DATA_W-1:0] shift_q;
  logic              parity_q;
  logic [IW-1:0]     bit_idx_q;
  logic              tx_q;
  logic              rd_q;
  logic              busy_q;
  logic              done_q;

  logic baud_load;
  logic bit_end;
  logic bit_pre_end;

  // Keep the bit counter parked until the start bit begins.
  assign baud_load = (state_q == ST_IDLE) || (state_q == ST_FETCH) ||
                     (state_q == ST_CAPTURE);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk          (clk),
    .rst_ni       (rst),
    .load_i       (baud_load),
    .bit_end_o    (bit_end),
    .bit_pre_end_o(bit_pre_end)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
      rd_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      rd_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          tx_q <= 1'b1;
          if (enable && !fifo_empty) begin
            rd_q    <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          state_q <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          shift_q   <= fifo_data;
          parity_q  <= (^fifo_data) ^ 1'(PARITY_ODD);
          bit_idx_q <= '0;
          tx_q      <= 1'b0;
          state_q   <= ST_START;
        end
        ST_START: begin
          if (bit_end) begin
            tx_q    <= shift_q[0];
            shift_q <= shift_q >> 1;
            state_q <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            if (bit_idx_q == LAST_DATA) begin
              bit_idx_q <= '0;
              if (PARITY_EN != 0) begin
                tx_q    <= parity_q;
                state_q <= ST_PARITY;
              end else begin
                tx_q    <= 1'b1;
                state_q <= ST_STOP;
              end
            end else begin
              tx_q      <= shift_q[0];
              shift_q   <= shift_q >> 1;
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (bit_end) begin
            tx_q      <= 1'b1;
            bit_idx_q <= '0;
            state_q   <= ST_STOP;
          end
        end
        ST_STOP: begin
          tx_q <= 1'b1;
          if (bit_pre_end && bit_idx_q == LAST_STOP) begin
            done_q <= 1'b1;
          end
          if (bit_end) begin
            if (bit_idx_q == LAST_STOP) begin
              busy_q    <= 1'b0;
              bit_idx_q <= '0;
              state_q   <= ST_IDLE;
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign fifo_rd    = rd_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: three instances (no parity, even, odd) each fed by a
// small synchronous FIFO; line activity is logged per cycle and decoded afterwards.
module tb_fifo_uart_tx;

  localparam int C    = 4;
  localparam int HMAX = 8192;

  logic clk = 1'b0;
  logic rst_n;
  logic fifo_clr;

  logic       enable     [3];
  logic       wr_en      [3];
  logic [7:0] wr_data    [3];
  logic       fifo_empty [3];
  logic [7:0] fifo_data  [3];
  logic       fifo_rd    [3];
  logic       tx         [3];
  logic       busy       [3];
  logic       frame_done [3];

  logic [7:0] model_q [3][$];

  logic tx_hist   [3][HMAX];
  logic rd_hist   [3][HMAX];
  logic busy_hist [3][HMAX];
  logic done_hist [3][HMAX];
  int   cyc = 0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_inst
    logic [7:0] mem [8];
    logic [3:0] cnt;
    logic [2:0] wp, rp;
    logic [7:0] dout;
    logic       emp;
    logic       do_wr, do_rd;

    assign do_wr = wr_en[gi] && (cnt != 4'd8);
    assign do_rd = fifo_rd[gi] && (cnt != 4'd0);

    // Empty flag is registered from the old count, so it lags the count by a cycle.
    always @(posedge clk) begin
      if (fifo_clr) begin
        cnt  <= '0;
        wp   <= '0;
        rp   <= '0;
        dout <= '0;
        emp  <= 1'b1;
      end else begin
        if (do_wr) begin
          mem[wp] <= wr_data[gi];
          wp      <= wp + 1'b1;
        end
        if (do_rd) begin
          dout <= mem[rp];
          rp   <= rp + 1'b1;
        end
        cnt <= cnt + {3'b0, do_wr} - {3'b0, do_rd};
        emp <= (cnt == 4'd0);
      end
    end

    assign fifo_empty[gi] = emp;
    assign fifo_data[gi]  = dout;

    fifo_uart_tx #(
      .CLKS_PER_BIT(C),
      .DATA_W      (8),
      .PARITY_EN   ((gi > 0) ? 1 : 0),
      .PARITY_ODD  ((gi == 2) ? 1 : 0),
      .STOP_BITS   (1)
    ) u_dut (
      .clk       (clk),
      .rst       (rst_n),
      .enable    (enable[gi]),
      .fifo_empty(fifo_empty[gi]),
      .fifo_data (fifo_data[gi]),
      .fifo_rd   (fifo_rd[gi]),
      .tx        (tx[gi]),
      .busy      (busy[gi]),
      .frame_done(frame_done[gi])
    );
  end

  always @(negedge clk) begin
    if (cyc < HMAX) begin
      for (int i = 0; i < 3; i++) begin
        tx_hist[i][cyc]   <= tx[i];
        rd_hist[i][cyc]   <= fifo_rd[i];
        busy_hist[i][cyc] <= busy[i];
        done_hist[i][cyc] <= frame_done[i];
      end
    end
    cyc <= cyc + 1;
  end

  // Expected line level at a cycle offset from the pop strobe.
  function automatic logic exp_tx(input logic [7:0] b, input int pe, input int po, input int off);
    int k;
    if (off < 2) return 1'b1;
    k = (off - 2) / C;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (pe != 0 && k == 9) return (^b) ^ (po != 0);
    return 1'b1;
  endfunction

  task automatic write_byte(input int inst, input logic [7:0] b);
    wr_en[inst]   = 1'b1;
    wr_data[inst] = b;
    model_q[inst].push_back(b);
    @(negedge clk);
    wr_en[inst] = 1'b0;
  endtask

  task automatic wait_rd(input int inst, input int budget, output int t, output bit ok);
    ok = 1'b0;
    t  = cyc;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (fifo_rd[inst] === 1'b1) begin
        ok = 1'b1;
        t  = cyc;
        break;
      end
    end
  endtask

  task automatic wait_quiet(input int inst, input int budget, input string name);
    int quiet;
    quiet = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (busy[inst] === 1'b0 && fifo_rd[inst] === 1'b0) quiet++;
      else quiet = 0;
      if (quiet >= 8) break;
    end
    total++;
    if (quiet < 8) begin
      bad++;
      $display("FAIL %s quiet_timeout: got quiet=%0d want 8 within %0d cycles", name, quiet, budget);
    end
  endtask

  task automatic check_frames(input int inst, input int ts, input int nexp, input string name,
                              output int first_t);
    int n, ndone, prev, L, pe, po, te, errs, first_bad;
    logic [7:0] b;
    pe = (inst > 0) ? 1 : 0;
    po = (inst == 2) ? 1 : 0;
    L  = (10 + pe) * C;
    te = cyc;
    n = 0; ndone = 0; prev = -1; first_t = -1;
    for (int t = ts; t < te; t++) begin
      if (done_hist[inst][t] === 1'b1) ndone++;
      if (t > 0 && rd_hist[inst][t] === 1'b1 && rd_hist[inst][t-1] !== 1'b1) begin
        n++;
        if (first_t < 0) first_t = t;
        total++;
        if (model_q[inst].size() == 0 || t + L + 2 >= te) begin
          bad++;
          $display("FAIL %s frame%0d: got unexpected or incomplete pop at cycle %0d want none", name, n, t);
          continue;
        end
        b = model_q[inst].pop_front();
        errs = 0; first_bad = -1;
        for (int off = 0; off <= L + 1; off++) begin
          if (tx_hist[inst][t+off] !== exp_tx(b, pe, po, off)) begin
            errs++;
            if (first_bad < 0) first_bad = off;
          end
        end
        if (errs != 0) begin
          bad++;
          $display("FAIL %s frame%0d tx byte=%02h: got %0d wrong cycles (first at offset %0d) want 0",
                   name, n, b, errs, first_bad);
        end
        total++;
        if (done_hist[inst][t+L+1] !== 1'b1 || done_hist[inst][t+L] !== 1'b0 ||
            done_hist[inst][t+L+2] !== 1'b0) begin
          bad++;
          $display("FAIL %s frame%0d frame_done: got %b%b%b at offsets %0d..%0d want 010",
                   name, n, done_hist[inst][t+L], done_hist[inst][t+L+1], done_hist[inst][t+L+2], L, L + 2);
        end
        total++;
        if (busy_hist[inst][t] !== 1'b1 || busy_hist[inst][t+L+1] !== 1'b1 ||
            busy_hist[inst][t+L+2] !== 1'b0 || rd_hist[inst][t+1] !== 1'b0) begin
          bad++;
          $display("FAIL %s frame%0d busy/strobe: got busy %b,%b,%b rd_next=%b want 1,1,0 rd_next=0",
                   name, n, busy_hist[inst][t], busy_hist[inst][t+L+1], busy_hist[inst][t+L+2],
                   rd_hist[inst][t+1]);
        end
        if (prev >= 0) begin
          total++;
          if (t - prev - L < 3) begin
            bad++;
            $display("FAIL %s frame%0d gap: got %0d idle cycles want >= 3", name, n, t - prev - L);
          end
        end
        prev = t;
      end
    end
    total++;
    if (n != nexp) begin
      bad++;
      $display("FAIL %s pop_count: got %0d want %0d", name, n, nexp);
    end
    total++;
    if (ndone != nexp) begin
      bad++;
      $display("FAIL %s done_count: got %0d want %0d", name, ndone, nexp);
    end
    $display("%s: inst=%0d frames=%0d", name, inst, n);
  endtask

  task automatic test_reset;
    enable[0] = 1'b1;
    write_byte(0, 8'hA5);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      total++;
      if (tx[0] !== 1'b1 || fifo_rd[0] !== 1'b0 || busy[0] !== 1'b0 || frame_done[0] !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold cyc%0d: got tx=%b rd=%b busy=%b done=%b want 1 0 0 0",
                 i, tx[0], fifo_rd[0], busy[0], frame_done[0]);
      end
    end
    total++;
    if (fifo_empty[0] !== 1'b0) begin
      bad++;
      $display("FAIL reset_fifo_kept: got empty=%b want 0", fifo_empty[0]);
    end
    $display("test_reset: done");
  endtask

  task automatic test_single_byte;
    int ts, t, ft;
    bit ok;
    ts = cyc;
    rst_n = 1'b1;
    wait_rd(0, 20, t, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL single_rd: got no pop want one within 20 cycles");
    end
    wait_quiet(0, 200, "single");
    check_frames(0, ts, 1, "single", ft);
    total++;
    if (ft != t || tx_hist[0][t+1] !== 1'b1 || tx_hist[0][t+2] !== 1'b0) begin
      bad++;
      $display("FAIL single_latency: got first_pop=%0d tx(+1,+2)=%b%b want pop=%0d tx=10",
               ft, tx_hist[0][t+1], tx_hist[0][t+2], t);
    end
  endtask

  task automatic test_burst;
    int ts, ft;
    ts = cyc;
    write_byte(0, 8'h00);
    write_byte(0, 8'hFF);
    write_byte(0, 8'h55);
    wait_quiet(0, 400, "burst");
    check_frames(0, ts, 3, "burst", ft);
    total++;
    if (fifo_empty[0] !== 1'b1) begin
      bad++;
      $display("FAIL burst_fifo_empty: got %b want 1", fifo_empty[0]);
    end
  endtask

  task automatic test_parity;
    int ts, ft;
    logic want;
    for (int inst = 1; inst < 3; inst++) begin
      enable[inst] = 1'b1;
      ts = cyc;
      write_byte(inst, 8'h07);
      wait_quiet(inst, 200, "parity");
      check_frames(inst, ts, 1, "parity", ft);
      want = (inst == 1) ? 1'b1 : 1'b0;
      total++;
      if (ft < 0 || tx_hist[inst][ft+2+9*C+1] !== want) begin
        bad++;
        $display("FAIL parity_bit inst%0d: got %b want %b", inst,
                 (ft < 0) ? 1'bx : tx_hist[inst][ft+2+9*C+1], want);
      end
      total++;
      if (ft < 0 || done_hist[inst][ft+2+44-1] !== 1'b1) begin
        bad++;
        $display("FAIL parity_len inst%0d: got done=0 at frame cycle 44 want 1", inst);
      end
    end
  endtask

  task automatic test_random;
    int ts, n, ft;
    for (int inst = 0; inst < 3; inst++) begin
      enable[inst] = 1'b1;
      n  = $urandom_range(2, 5);
      ts = cyc;
      for (int k = 0; k < n; k++) write_byte(inst, 8'($urandom));
      wait_quiet(inst, 800, "random");
      check_frames(inst, ts, n, "random", ft);
      total++;
      if (fifo_empty[inst] !== 1'b1 || model_q[inst].size() != 0) begin
        bad++;
        $display("FAIL random_drain inst%0d: got empty=%b left=%0d want 1 0",
                 inst, fifo_empty[inst], model_q[inst].size());
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    int t, ts, ft;
    bit ok;
    logic [7:0] b1, drop;
    b1 = 8'($urandom) & 8'hF7;
    write_byte(0, b1);
    write_byte(0, 8'($urandom));
    wait_rd(0, 20, t, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL midrst_rd: got no pop want one within 20 cycles");
    end
    drop = model_q[0].pop_front();
    repeat (19) @(negedge clk);
    total++;
    if (tx[0] !== drop[3]) begin
      bad++;
      $display("FAIL midrst_bit3: got %b want %b", tx[0], drop[3]);
    end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (tx[0] !== 1'b1 || busy[0] !== 1'b0 || fifo_rd[0] !== 1'b0 || frame_done[0] !== 1'b0) begin
      bad++;
      $display("FAIL midrst_outputs: got tx=%b busy=%b rd=%b done=%b want 1 0 0 0",
               tx[0], busy[0], fifo_rd[0], frame_done[0]);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    ts = cyc;
    wait_quiet(0, 200, "post_reset");
    check_frames(0, ts, 1, "post_reset", ft);
  endtask

  task automatic test_enable;
    int ts, t, ft;
    bit ok;
    enable[0] = 1'b0;
    ts = cyc;
    write_byte(0, 8'($urandom));
    write_byte(0, 8'($urandom));
    repeat (30) @(negedge clk);
    check_frames(0, ts, 0, "enable_off", ft);
    model_q[0].push_front(8'h00);
    model_q[0].pop_front();
    enable[0] = 1'b1;
    wait_rd(0, 20, t, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL enable_rd: got no pop want one within 20 cycles");
    end
    repeat (10) @(negedge clk);
    enable[0] = 1'b0;
    wait_quiet(0, 200, "enable_drop");
    check_frames(0, t, 1, "enable_drop", ft);
    total++;
    if (model_q[0].size() != 1 || fifo_empty[0] !== 1'b0) begin
      bad++;
      $display("FAIL enable_left: got left=%0d empty=%b want 1 0", model_q[0].size(), fifo_empty[0]);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    fifo_clr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      enable[i]  = 1'b0;
      wr_en[i]   = 1'b0;
      wr_data[i] = 8'h00;
    end
    repeat (2) @(negedge clk);
    fifo_clr = 1'b0;

    test_reset;
    test_single_byte;
    test_burst;
    test_parity;
    test_random;
    test_reset_mid_frame;
    test_enable;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
